status_monitor: RTL and testbench

Synthesizable receiver for the core's `o_status` / `o_status_valid` stream. It arms on a start pulse and writes every valid status code into an on-chip buffer in arrival order. It stops on the first halting code (MIPS_OVERFLOW or MIPS_END), on buffer overflow, or on a cycle-budget timeout. It lets a host or debug port read back the captured sequence and the termination reason, so the self-check loop can run on silicon/FPGA without a simulator.

---
 rtl/status_monitor.sv | 119 +++++++++++
 tb/tb_status_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/status_monitor.sv
// Captures the core's status stream into an on-chip buffer until a halting code,
// a full buffer or the cycle budget ends the run; the buffer is readable at any time.
module status_monitor #(
    parameter int DEPTH     = 1024,
    parameter int IDX_W     = 10,
    parameter int MAX_CYCLE = 120000,
    parameter int CYC_W     = 17
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_status,
    input  logic             i_status_valid,
    input  logic             i_rd_en,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_data,
    output logic             o_rd_valid,
    output logic [IDX_W:0]   o_count,
    output logic [CYC_W-1:0] o_cycles,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_halt_code,
    output logic             o_overflow,
    output logic             o_timeout
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE, TIMEOUT} state_t;

    localparam logic [CYC_W-1:0] LAST_CYCLE = CYC_W'(MAX_CYCLE - 1);
    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W + 1)'(DEPTH);

    state_t           state;
    logic [1:0]       mem [DEPTH];
    logic [1:0]       rd_raw;
    logic             rd_hit;
    logic             wr_en;
    logic             is_halt;
    logic [IDX_W:0]   count_next;

    // A valid arriving together with i_start belongs to no run and is dropped.
    assign wr_en   = (state == CAPTURE) && i_status_valid && !i_start;
    assign is_halt = i_status[1];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_next = o_count;
        if (i_start)
            count_next = '0;
        else if (wr_en)
            count_next = o_count + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            o_count     <= '0;
            o_cycles    <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_halt_code <= 2'd0;
            o_overflow  <= 1'b0;
            o_timeout   <= 1'b0;
        end else if (i_start) begin
            state       <= CAPTURE;
            o_count     <= '0;
            o_cycles    <= '0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            o_halt_code <= 2'd0;
            o_overflow  <= 1'b0;
            o_timeout   <= 1'b0;
        end else if (state == CAPTURE) begin
            // Saturating at the last budget cycle leaves o_cycles at MAX_CYCLE-1 on exit.
            if (o_cycles != LAST_CYCLE)
                o_cycles <= o_cycles + 1'b1;
            o_count <= count_next;
            if (wr_en && is_halt) begin
                o_halt_code <= i_status;
                o_done      <= 1'b1;
                o_busy      <= 1'b0;
                state       <= DONE;
            end else if (wr_en && (count_next == FULL_COUNT)) begin
                o_overflow <= 1'b1;
                o_done     <= 1'b1;
                o_busy     <= 1'b0;
                state      <= DONE;
            end else if (o_cycles == LAST_CYCLE) begin
                o_timeout <= 1'b1;
                o_busy    <= 1'b0;
                state     <= TIMEOUT;
            end
        end
    end

    // NOTE: the buffer has no reset; its contents are don't-care until written, which keeps it RAM-mappable.
    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[o_count[IDX_W-1:0]] <= i_status;
        if (i_rd_en)
            rd_raw <= mem[i_rd_idx];
    end

    // The hit test uses the post-edge count so a read colliding with a write
    // returns the slot's previous contents rather than zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_valid <= 1'b0;
            rd_hit     <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en;
            if (i_rd_en)
                rd_hit <= ({1'b0, i_rd_idx} < count_next);
        end
    end

    assign o_rd_data = rd_hit ? rd_raw : 2'd0;

endmodule

// File: tb/tb_status_monitor.sv
// Directed self-checking bench for status_monitor with a shortened cycle budget.
module tb_status_monitor;

    localparam int DEPTH     = 1024;
    localparam int IDX_W     = 10;
    localparam int MAX_CYCLE = 1500;
    localparam int CYC_W     = 17;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic [1:0]       i_status = 2'd0;
    logic             i_status_valid = 1'b0;
    logic             i_rd_en = 1'b0;
    logic [IDX_W-1:0] i_rd_idx = '0;
    logic [1:0]       o_rd_data;
    logic             o_rd_valid;
    logic [IDX_W:0]   o_count;
    logic [CYC_W-1:0] o_cycles;
    logic             o_busy;
    logic             o_done;
    logic [1:0]       o_halt_code;
    logic             o_overflow;
    logic             o_timeout;

    int checks = 0;
    int errors = 0;

    status_monitor #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .MAX_CYCLE(MAX_CYCLE), .CYC_W(CYC_W)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_status(i_status), .i_status_valid(i_status_valid),
        .i_rd_en(i_rd_en), .i_rd_idx(i_rd_idx),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_count(o_count), .o_cycles(o_cycles), .o_busy(o_busy),
        .o_done(o_done), .o_halt_code(o_halt_code),
        .o_overflow(o_overflow), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs set before step() are sampled on its edge; outputs are read 1 ns later.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic send(input logic [1:0] code);
        i_status = code;
        i_status_valid = 1'b1;
        step();
        i_status_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic rd_check(input string tag, input int idx, input logic [1:0] exp);
        i_rd_en = 1'b1;
        i_rd_idx = IDX_W'(idx);
        step();
        i_rd_en = 1'b0;
        check({tag, "_valid"}, o_rd_valid, 1);
        check(tag, o_rd_data, exp);
    endtask

    task automatic flags(input string tag, input int count, input int done, input int halt,
                         input int ovf, input int tmo, input int busy);
        check({tag, "_count"}, o_count, count);
        check({tag, "_done"}, o_done, done);
        check({tag, "_halt"}, o_halt_code, halt);
        check({tag, "_ovf"}, o_overflow, ovf);
        check({tag, "_tmo"}, o_timeout, tmo);
        check({tag, "_busy"}, o_busy, busy);
    endtask

    logic [1:0] normal_seq [5] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd3};

    initial begin
        // Reset state
        idle(3);
        i_rst = 1'b0;
        step();
        flags("rst", 0, 0, 0, 0, 0, 0);
        check("rst_cycles", o_cycles, 0);
        check("rst_rdv", o_rd_valid, 0);
        check("rst_rdd", o_rd_data, 0);
        idle(2);
        check("idle_ignores_valid_pre", o_count, 0);

        // Status valid in IDLE is ignored
        send(2'd3);
        check("idle_ignores_valid", o_count, 0);

        // Normal run: 0,1,1,0,3 with gaps; valid on the start cycle is dropped
        i_status = 2'd2;
        i_status_valid = 1'b1;
        start();
        i_status_valid = 1'b0;
        check("norm_start_count", o_count, 0);
        check("norm_start_busy", o_busy, 1);
        send(2'd0); idle(1); send(2'd1); send(2'd1); idle(1);
        send(2'd0); idle(2); send(2'd3);
        flags("norm", 5, 1, 3, 0, 0, 0);
        check("norm_cycles", o_cycles, 9);
        idle(3);
        check("norm_cycles_hold", o_cycles, 9);
        check("norm_done_hold", o_done, 1);
        send(2'd1);
        check("done_ignores_valid", o_count, 5);

        // Back-to-back readout, out-of-range index first
        i_rd_en = 1'b1;
        i_rd_idx = IDX_W'(5);
        step();
        check("norm_rd5", o_rd_data, 0);
        for (int i = 0; i < 5; i++) begin
            i_rd_idx = IDX_W'(i);
            step();
            check("norm_rd_valid", o_rd_valid, 1);
            check($sformatf("norm_rd%0d", i), o_rd_data, normal_seq[i]);
        end
        i_rd_en = 1'b0;
        i_rd_idx = '0;
        step();
        check("rd_valid_pulse", o_rd_valid, 0);
        check("rd_data_hold", o_rd_data, 3);

        // Overflow halt code 2; later codes ignored
        start();
        flags("ovh_start", 0, 0, 0, 0, 0, 1);
        check("ovh_start_cycles", o_cycles, 0);
        send(2'd1); send(2'd2); send(2'd1); send(2'd0);
        flags("ovh", 2, 1, 2, 0, 0, 0);
        rd_check("ovh_rd0", 0, 2'd1);
        rd_check("ovh_rd1", 1, 2'd2);
        rd_check("ovh_rd2", 2, 2'd0);

        // Buffer overflow: 1024 consecutive code-0 entries
        start();
        i_status = 2'd0;
        i_status_valid = 1'b1;
        idle(DEPTH - 1);
        check("bof_pre_count", o_count, DEPTH - 1);
        check("bof_pre_busy", o_busy, 1);
        step();
        flags("bof", DEPTH, 1, 0, 1, 0, 0);
        check("bof_cycles", o_cycles, DEPTH);
        step();
        i_status_valid = 1'b0;
        check("bof_after_count", o_count, DEPTH);
        rd_check("bof_rd_last", DEPTH - 1, 2'd0);

        // Halt code in the last slot: done without overflow
        start();
        i_status = 2'd0;
        i_status_valid = 1'b1;
        idle(DEPTH - 1);
        i_status_valid = 1'b0;
        send(2'd3);
        flags("bof3", DEPTH, 1, 3, 0, 0, 0);
        rd_check("bof3_rd_last", DEPTH - 1, 2'd3);
        rd_check("bof3_rd_first", 0, 2'd0);

        // Timeout with no valids
        start();
        idle(MAX_CYCLE - 1);
        check("tmo_pre_busy", o_busy, 1);
        check("tmo_pre_cycles", o_cycles, MAX_CYCLE - 1);
        check("tmo_pre_tmo", o_timeout, 0);
        step();
        flags("tmo", 0, 0, 0, 0, 1, 0);
        check("tmo_cycles", o_cycles, MAX_CYCLE - 1);
        send(2'd0);
        check("tmo_ignores_valid", o_count, 0);
        check("tmo_cycles_hold", o_cycles, MAX_CYCLE - 1);

        // Halt code on the final budget cycle wins over timeout
        start();
        check("tmo3_start_tmo", o_timeout, 0);
        idle(MAX_CYCLE - 1);
        send(2'd3);
        flags("tmo3", 1, 1, 3, 0, 0, 0);
        check("tmo3_cycles", o_cycles, MAX_CYCLE - 1);

        // Reset mid-capture after three entries
        start();
        send(2'd1); send(2'd0); send(2'd1);
        check("mid_count", o_count, 3);
        i_rst = 1'b1;
        #1;
        flags("async_rst", 0, 0, 0, 0, 0, 0);
        step();
        i_rst = 1'b0;
        step();
        flags("mid_rst", 0, 0, 0, 0, 0, 0);
        check("mid_rst_cycles", o_cycles, 0);
        check("mid_rst_rdd", o_rd_data, 0);
        start();
        send(2'd3);
        flags("post_rst", 1, 1, 3, 0, 0, 0);

        // Start during CAPTURE clears the count
        start();
        send(2'd1); send(2'd0);
        check("restart_pre_count", o_count, 2);
        start();
        check("restart_count", o_count, 0);
        check("restart_busy", o_busy, 1);
        check("restart_cycles", o_cycles, 0);

        // Read collides with the first write: old buffer[0] (1) is returned
        i_rd_en = 1'b1;
        i_rd_idx = '0;
        send(2'd2);
        i_rd_en = 1'b0;
        check("coll_rdv", o_rd_valid, 1);
        check("coll_rdd", o_rd_data, 1);
        flags("coll", 1, 1, 2, 0, 0, 0);
        rd_check("coll_rd_new", 0, 2'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
